// File: rtl/uart_txd.sv
// UART transmitter: 8 data bits, optional even/odd parity, one stop bit.
// A one-byte holding register behind a valid/rdy handshake keeps frames back-to-back.
module uart_txd #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int PARITY    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       rdy,
    output logic       txd,
    output logic       busy
);

    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Mode 2 (odd) inverts the plain XOR used for even parity.
    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        return (mode == 2) ? ~(^d) : (^d);
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_next_s;
    logic             hold_full_r;
    logic [7:0]       hold_data_r;
    logic [7:0]       shift_r;
    logic             par_r;
    logic             txd_r;
    logic             busy_r;
    logic             load_s;
    logic             accept_s;
    logic             bit_end_s;
    logic             txd_next_s;

    assign rdy  = ~hold_full_r;
    assign txd  = txd_r;
    assign busy = busy_r;

    // Next-state, counter and line-level decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        load_s       = 1'b0;
        txd_next_s   = 1'b1;
        accept_s     = valid & ~hold_full_r;
        bit_end_s    = (cnt_r == CNT_LAST);

        case (state_r)
            ST_IDLE: begin
                cnt_next_s = '0;
                idx_next_s = 3'd0;
                if (hold_full_r) begin
                    state_next_s = ST_START;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_next_s   = '0;
                    state_next_s = ST_DATA;
                end else begin
                    cnt_next_s = cnt_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_next_s = '0;
                    if (idx_r == 3'd7) begin
                        idx_next_s   = 3'd0;
                        state_next_s = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r + 1'b1;
                end
            end
            ST_PAR: begin
                if (bit_end_s) begin
                    cnt_next_s   = '0;
                    state_next_s = ST_STOP;
                end else begin
                    cnt_next_s = cnt_r + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_next_s = '0;
                    if (hold_full_r) begin
                        state_next_s = ST_START;
                        load_s       = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
                idx_next_s   = 3'd0;
            end
        endcase

        // The line follows the state one clock later, so every bit still spans BIT_CYC clocks.
        case (state_r)
            ST_IDLE:  txd_next_s = 1'b1;
            ST_START: txd_next_s = 1'b0;
            ST_DATA:  txd_next_s = shift_r[idx_r];
            ST_PAR:   txd_next_s = par_r;
            ST_STOP:  txd_next_s = 1'b1;
            default:  txd_next_s = 1'b1;
        endcase
    end

    // FSM, bit counter, bit index and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            txd_r   <= txd_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Holding register: filled by the handshake, emptied when the shifter loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full_r <= 1'b0;
            hold_data_r <= 8'h00;
        end else if (load_s) begin
            hold_full_r <= 1'b0;
        end else if (accept_s) begin
            hold_full_r <= 1'b1;
            hold_data_r <= data;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    // Shift register and parity are frozen for the whole frame once loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r <= 8'h00;
            par_r   <= 1'b0;
        end else if (load_s) begin
            shift_r <= hold_data_r;
            par_r   <= parity_bit(hold_data_r, PARITY);
        end else begin
            shift_r <= shift_r;
        end
    end

endmodule

// File: tb/tb_uart_txd.sv
// Directed bench for uart_txd: three instances (no/even/odd parity) with a 16-clock bit period.
module tb_uart_txd;

    // 165 / 10 truncates to 16 clocks per bit.
    localparam int BC = 16;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       rdy0, txd0, busy0;
    logic       rdy1, txd1, busy1;
    logic       rdy2, txd2, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    uart_txd #(.CLK_FREQ(165), .BAUD_RATE(10), .PARITY(0)) u0 (
        .clk(clk), .rst(rst), .valid(valid), .data(data),
        .rdy(rdy0), .txd(txd0), .busy(busy0));
    uart_txd #(.CLK_FREQ(165), .BAUD_RATE(10), .PARITY(1)) u1 (
        .clk(clk), .rst(rst), .valid(valid), .data(data),
        .rdy(rdy1), .txd(txd1), .busy(busy1));
    uart_txd #(.CLK_FREQ(165), .BAUD_RATE(10), .PARITY(2)) u2 (
        .clk(clk), .rst(rst), .valid(valid), .data(data),
        .rdy(rdy2), .txd(txd2), .busy(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic txd_of(input int inst);
        case (inst)
            1:       return txd1;
            2:       return txd2;
            default: return txd0;
        endcase
    endfunction

    function automatic logic busy_of(input int inst);
        case (inst)
            1:       return busy1;
            2:       return busy2;
            default: return busy0;
        endcase
    endfunction

    // Entered at the first clock of the start bit; returns at the clock after the stop bit.
    task automatic check_frame(input int inst, input logic [7:0] b, input logic has_par,
                               input logic exp_par, input string tag);
        logic [10:0] bits;
        int          nb;
        int          mism;
        bits       = 11'h7FF;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        if (has_par) begin
            bits[9] = exp_par;
            nb      = 11;
        end else begin
            nb      = 10;
        end
        for (int j = 0; j < nb; j++) begin
            mism = 0;
            for (int c = 0; c < BC; c++) begin
                if (txd_of(inst) !== bits[j]) mism++;
                if (j == nb - 1 && c == 0)
                    check($sformatf("%s_busy_in_stop", tag), busy_of(inst), 1);
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", tag, j), mism, 0);
        end
    endtask

    task automatic idle_check(input string tag, input int nbits);
        int bad_txd = 0;
        int bad_busy = 0;
        int bad_rdy = 0;
        for (int c = 0; c < nbits * BC; c++) begin
            @(negedge clk);
            if (txd0 !== 1'b1)  bad_txd++;
            if (busy0 !== 1'b0) bad_busy++;
            if (rdy0 !== 1'b1)  bad_rdy++;
        end
        check({tag, "_txd"},  bad_txd, 0);
        check({tag, "_busy"}, bad_busy, 0);
        check({tag, "_rdy"},  bad_rdy, 0);
    endtask

    // One-cycle valid pulse; returns at the negedge right after the accepting edge.
    task automatic accept_byte(input logic [7:0] b);
        @(negedge clk);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [3];
        int w;
        seq[0] = 8'h11;
        seq[1] = 8'h22;
        seq[2] = 8'h33;
        rst   = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", txd0, 1);
        check("rst_rdy", rdy0, 1);
        check("rst_busy", busy0, 0);
        check("rst_busy_par", busy1, 0);
        rst = 1'b1;
        idle_check("idle20", 20);

        // Single 0x55 frame with exact handshake latency.
        accept_byte(8'h55);
        check("acc_rdy_low", rdy0, 0);
        check("acc_busy_low", busy0, 0);
        check("acc_txd_idle", txd0, 1);
        @(negedge clk);
        check("load_rdy_high", rdy0, 1);
        check("load_busy", busy0, 1);
        check("load_txd_idle", txd0, 1);
        @(negedge clk);
        check_frame(0, 8'h55, 1'b0, 1'b0, "f55");
        check("f55_busy_end", busy0, 0);
        check("f55_txd_end", txd0, 1);
        check("f55_rdy_end", rdy0, 1);

        // Three bytes with valid held high: frames must abut with no idle.
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int n = 0;
                    valid = 1'b1;
                    data  = seq[i];
                    while (rdy0 !== 1'b1 && n < 1000) begin
                        @(negedge clk);
                        n++;
                    end
                    check($sformatf("feed%0d_in_time", i), (n < 1000), 1);
                    @(negedge clk);
                    check($sformatf("feed%0d_rdy_full", i), rdy0, 0);
                end
                valid = 1'b0;
            end
            begin
                w = 0;
                while (txd0 !== 1'b0 && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                check("b2b_start_latency", w, 3);
                check_frame(0, 8'h11, 1'b0, 1'b0, "b2b11");
                check_frame(0, 8'h22, 1'b0, 1'b0, "b2b22");
                check_frame(0, 8'h33, 1'b0, 1'b0, "b2b33");
                check("b2b_busy_end", busy0, 0);
                check("b2b_txd_end", txd0, 1);
            end
        join
        idle_check("b2b_no_dup", 2);

        // Reset in the middle of data bit 3 of 0xF0.
        accept_byte(8'hF0);
        repeat (2) @(negedge clk);
        repeat (4 * BC + BC / 2) @(negedge clk);
        check("pre_rst_d3", txd0, 0);
        check("pre_rst_busy", busy0, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_txd", txd0, 1);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_rdy", rdy0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle_check("post_rst_idle", 20);

        // Parity: 0x07 has three ones, so even parity is 1 and odd parity is 0.
        accept_byte(8'h07);
        @(negedge clk);
        @(negedge clk);
        fork
            check_frame(1, 8'h07, 1'b1, 1'b1, "even07");
            check_frame(2, 8'h07, 1'b1, 1'b0, "odd07");
        join
        check("even07_busy_end", busy1, 0);
        check("odd07_busy_end", busy2, 0);
        check("even07_txd_end", txd1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_txd.md
UART_TXD -- requirements
Module: uart_txd

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-003 Parameter PARITY, default 0; 0 = none, 1 = even, 2 = odd.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 valid  input  1  upstream has a byte on data.
REQ-007 data  input  8  byte to transmit.
REQ-008 rdy  output  1  holding register empty; a byte is accepted this cycle if valid is high.
REQ-009 txd  output  1  serial line, idle high, drives uart_rxd rxd.
REQ-010 busy  output  1  frame in progress on txd.

Function
REQ-011 BIT_CYC SHALL be CLK_FREQ/BAUD_RATE, integer truncation (10416 at defaults); every bit, including start, parity and stop, SHALL last exactly BIT_CYC clocks.
REQ-012 Frame SHALL be: start bit 0; data[0] first through data[7]; parity bit if PARITY != 0; one stop bit 1.
REQ-013 Even parity bit SHALL be XOR of the 8 data bits; odd parity bit SHALL be its inverse.
REQ-014 A transfer SHALL occur on a rising edge where valid and rdy are both high; data SHALL be captured into a holding register and rdy SHALL fall after that edge.
REQ-015 rdy SHALL equal the inverse of the holding-register-full flag; it SHALL NOT depend combinationally on valid.
REQ-016 data SHALL be ignored whenever rdy is low; valid held high SHALL NOT cause a duplicate transfer.
REQ-017 FSM states: IDLE, START, DATA, PAR, STOP.
REQ-018 IDLE -> START at the first edge where the holding register is full; at that edge the holding byte moves to the shift register and the holding register empties, so rdy rises.
REQ-019 START -> DATA after BIT_CYC clocks; DATA -> PAR (PARITY != 0) or STOP (PARITY == 0) after 8 bit periods; PAR -> STOP after BIT_CYC clocks.
REQ-020 STOP, after BIT_CYC clocks: -> START if the holding register is full (back-to-back frames, zero idle clocks), otherwise -> IDLE.
REQ-021 A byte accepted while the FSM is in IDLE with the holding register empty SHALL put the start bit on txd exactly 2 clocks after the accepting edge (1 clock to load the shifter, 1 clock registered output).
REQ-022 txd SHALL be driven from a flip-flop; txd SHALL have no glitches within a bit period.
REQ-023 busy SHALL be high in every state except IDLE.
REQ-024 A new byte accepted during any frame SHALL NOT alter the frame in progress.
REQ-025 The bit counter SHALL count 0..BIT_CYC-1 and wrap to 0; the data-bit index SHALL count 0..7 and wrap to 0.

Reset
REQ-026 While rst is low: txd = 1, rdy = 1, busy = 0, FSM = IDLE, counters = 0, holding register empty.
REQ-027 Asserting rst mid-frame SHALL abort the frame immediately and set txd to 1; the discarded byte SHALL NOT be sent after reset.
REQ-028 Operation SHALL resume on the first rising edge after rst is released.

Verification
REQ-029 Defaults, one transfer data=0x55 -> txd = 0,1,0,1,0,1,0,1,0,1, each level for 10416 clocks; busy falls after the stop bit; rdy high again 1 clock after acceptance.
REQ-030 PARITY=1, data=0x07 -> parity bit 1; PARITY=2, data=0x07 -> parity bit 0; frame length 11 bit periods.
REQ-031 valid held high with 0x11, 0x22, 0x33 presented in sequence -> three frames with no idle between stop and next start; rdy low while the holding register is full; no byte lost or duplicated.
REQ-032 Loopback txd -> uart_rxd rxd at 9600, send 0xA5 -> uart_rxd reports data = 0xA5, valid pulse, ferr = 0, oerr = 0.
REQ-033 rst low during data bit 3 of 0xF0 -> txd = 1 and busy = 0 within the reset period; after release txd remains idle high until a new transfer.
REQ-034 valid low throughout -> txd stays 1, busy stays 0, rdy stays 1 for 20 bit periods.
